gray_fifo_ctrl: RTL
===================

Name: gray_fifo_ctrl

Overview:
Single-clock FIFO pointer controller. Write and read pointers are kept in Gray code and each is advanced by one IncGrayC instance.
- Produces full/empty flags, binary RAM addresses, RAM enables, fill level and sticky error flags.
- Drives an external 2**AddrWidth-entry register file or SRAM.
- Gray pointers are exported so a later dual-clock variant can reuse the same pointer logic unchanged.

Parameters:
AddrWidth, 4, log2 of FIFO depth (depth = 2**AddrWidth); minimum 1.
Speed, 2, performance parameter forwarded to IncGrayC/PrefixAnd (0 serial, 1 Brent-Kung, 2 Sklansky).

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous clear of both pointers and error flags
push_i  input  1  write request
pop_i  input  1  read request
wr_en_o  output  1  RAM write enable (= accepted push)
rd_en_o  output  1  RAM read enable (= accepted pop)
wr_addr_o  output  AddrWidth  binary write address
rd_addr_o  output  AddrWidth  binary read address
wr_ptr_o  output  AddrWidth+1  Gray write pointer (registered)
rd_ptr_o  output  AddrWidth+1  Gray read pointer (registered)
full_o  output  1  FIFO full
empty_o  output  1  FIFO empty
usage_o  output  AddrWidth+1  entries stored, 0..2**AddrWidth
overflow_o  output  1  sticky: push while full
underflow_o  output  1  sticky: pop while empty

Behaviour:
- Clock clk_i; reset rst_i, synchronous, active-high.
- Reset values: wr_ptr = rd_ptr = 0, so empty_o = 1, full_o = 0, usage_o = 0, addresses 0, wr_en_o = rd_en_o = 0, overflow_o = underflow_o = 0.
- Pointers are AddrWidth+1 bit Gray registers. The next value is IncGrayC(A = ptr, CI = accept); CI = 0 holds the value.
- push_acc = push_i & ~full_o & ~flush_i; pop_acc = pop_i & ~empty_o & ~flush_i.
- wr_en_o = push_acc and rd_en_o = pop_acc, both combinational, same cycle as the request. The pointer advances on the following edge.
- empty_o = (wr_ptr == rd_ptr).
- full_o = (wr_ptr[MSB:MSB-1] == ~rd_ptr[MSB:MSB-1]) and (wr_ptr[MSB-2:0] == rd_ptr[MSB-2:0]). For AddrWidth = 1 only the 2-bit inversion test applies.
- Flags are combinational from registered pointers only. They never depend on push_i or pop_i in the same cycle (no fall-through).
- wr_addr_o and rd_addr_o are the low AddrWidth bits of gray2bin(ptr), combinational from the registers.
- usage_o = gray2bin(wr_ptr) - gray2bin(rd_ptr), modulo 2**(AddrWidth+1).
- Simultaneous push and pop:
  - Not full and not empty: both accepted, usage unchanged.
  - Full: only the pop is accepted; the push is rejected and sets overflow.
  - Empty: only the push is accepted; the pop is rejected and sets underflow.
- overflow_o is set on push_i & full_o & ~flush_i. underflow_o is set on pop_i & empty_o & ~flush_i. Both hold until rst_i or flush_i.
- flush_i has priority over push/pop: enables are low that cycle, and pointers and error flags are 0 next cycle. rst_i has priority over flush_i.
- Wrap-around: the pointer wraps from Gray(2**(AddrWidth+1)-1) to 0 through the incrementer's natural modular behaviour; no special case.
- Reset mid-operation discards all contents; RAM contents are don't-care afterwards.

Decomposition:
- Package gray_fifo_pkg:
  - gray2bin function (same XOR-suffix rule as behavioural_Gray2Bin).
  - is_full(wr, rd) function.
- Pointer type logic [AddrWidth:0] is declared locally because it depends on the parameter.
- One natural sub-module, gray_ptr_reg: register plus IncGrayC #(AddrWidth+1, Speed) with ports clk_i, rst_i, clr_i, inc_i, ptr_o. It is instantiated twice (write, read).

Test Plan:
1. AddrWidth = 2. Reset, then 4 single-cycle pushes.
   - wr_ptr_o sequence 000 -> 001 -> 011 -> 010 -> 110; wr_addr_o 0,1,2,3.
   - After the 4th push: full_o = 1, usage_o = 4, empty_o = 0.
2. From full, push_i = 1 and pop_i = 1 in the same cycle.
   - wr_en_o = 0, rd_en_o = 1, overflow_o = 1 next cycle.
   - rd_ptr_o 000 -> 001, usage_o = 3.
3. Empty FIFO, push and pop in the same cycle.
   - wr_en_o = 1, rd_en_o = 0, underflow_o = 1, usage_o = 1.
   - Next cycle empty_o = 0.
4. 20 cycles of continuous push+pop with 2 entries stored.
   - Pointers pass 110, 111, 101, 100 and wrap to 000.
   - usage_o constant at 2; no flags change.
5. flush_i asserted with push_i and pop_i high at usage 3.
   - Enables 0 that cycle; next cycle both pointers 000, empty_o = 1, error flags 0.
6. Random push/pop for 10k cycles for Speed 0, 1, 2.
   - Scoreboard checks flags, usage_o and binary addresses against a behavioural reference model.

Source files
------------

// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the Gray-coded FIFO pointer controller.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package gray_fifo_pkg;

    // Widest pointer the helpers handle. Callers zero-extend narrower pointers.
    localparam int PTR_W_MAX = 32;

    typedef logic [PTR_W_MAX-1:0] wide_t;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic wide_t gray2bin(input wide_t g);
        wide_t b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Full when the two top pointer bits (aw, aw-1) are both inverted and all
    // lower bits match. For aw = 1 this reduces to the 2-bit inversion test.
    function automatic logic is_full(input wide_t wr, input wide_t rd, input int aw);
        return (wr ^ rd) == (wide_t'(3) << (aw - 1));
    endfunction

endpackage

// File: rtl/gray_ptr_reg.sv
// One Gray-coded FIFO pointer: register plus incrementer.
// Latency: ptr_o advances on the edge after inc_i is sampled high.
// Backpressure: caller qualifies inc_i; clr_i and rst_i zero the pointer.
module gray_ptr_reg #(
    parameter int AddrWidth = 4,
    parameter int Speed     = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [AddrWidth:0] ptr_o
);

    logic [AddrWidth:0] ptr_nxt;

    inc_gray_c #(
        .Width(AddrWidth + 1),
        .Speed(Speed)
    ) u_inc (
        .a (ptr_o),
        .ci(inc_i),
        .z (ptr_nxt)
    );

    // Pointer register; reset and clear both return it to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            ptr_o <= '0;
        end else begin
            ptr_o <= ptr_nxt;
        end
    end

endmodule

// File: rtl/inc_gray_c.sv
// Gray-code incrementer with carry-in: z = gray(bin(a) + ci), wrapping modulo 2**Width.
// Latency: combinational.
// Backpressure: not applicable; ci = 0 passes a through unchanged.
module inc_gray_c #(
    parameter int Width = 5,
    parameter int Speed = 2
) (
    input  logic [Width-1:0] a,
    input  logic             ci,
    output logic [Width-1:0] z
);

    logic             par;
    logic [Width-2:0] zero_pre;
    logic [Width-1:0] az;
    logic [Width-1:0] tog;

    assign par = ^a;

    // zero_pre[j] = 1 when a[j:0] is all zero.
    prefix_and #(
        .Width(Width - 1),
        .Speed(Speed)
    ) u_pre (
        .d(~a[Width-2:0]),
        .q(zero_pre)
    );

    // az[k] = 1 when every bit below k is zero (az[0] is trivially true).
    assign az = {zero_pre, 1'b1};

    // Even parity flips bit 0; odd parity flips the bit just above the lowest set bit.
    // The MSB also absorbs the case where the lowest set bit is the MSB itself (wrap).
    always_comb begin
        tog = '0;
        tog[0] = ci & ~par;
        for (int k = 1; k < Width - 1; k++) begin
            tog[k] = ci & par & a[k-1] & az[k-1];
        end
        tog[Width-1] = ci & par & ((a[Width-2] & az[Width-2]) | az[Width-1]);
    end

    assign z = a ^ tog;

endmodule

// File: rtl/prefix_and.sv
// Prefix AND: q[i] = &d[i:0], structure chosen by Speed (0 serial, 1 Brent-Kung, 2 Sklansky).
// Latency: combinational.
// Backpressure: not applicable.
module prefix_and #(
    parameter int Width = 4,
    parameter int Speed = 2
) (
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    localparam int Levels = (Width > 1) ? $clog2(Width) : 1;

    logic [Width-1:0] p;

    // Build the prefix network in place; each level only reads nodes it does not write.
    always_comb begin
        p = d;
        if (Speed == 0) begin
            for (int i = 1; i < Width; i++) begin
                p[i] = p[i-1] & d[i];
            end
        end else if (Speed == 1) begin
            for (int l = 0; l < Levels; l++) begin
                for (int i = 0; i < Width; i++) begin
                    if (((i + 1) % (2 << l)) == 0) begin
                        p[i] = p[i] & p[i - (1 << l)];
                    end
                end
            end
            for (int l = Levels - 1; l >= 0; l--) begin
                for (int i = 0; i < Width; i++) begin
                    if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
                        p[i] = p[i] & p[i - (1 << l)];
                    end
                end
            end
        end else begin
            for (int l = 0; l < Levels; l++) begin
                for (int i = 0; i < Width; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        p[i] = p[i] & p[((i >> l) << l) - 1];
                    end
                end
            end
        end
        q = p;
    end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with Gray pointers, flags, addresses and sticky errors.
// Latency: enables same cycle as request; pointers, flags and usage update on the next edge.
// Backpressure: push refused while full, pop refused while empty; refusals set sticky errors.
module gray_fifo_ctrl
    import gray_fifo_pkg::*;
#(
    parameter int AddrWidth = 4,
    parameter int Speed     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    output logic                 wr_en_o,
    output logic                 rd_en_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [AddrWidth:0]   wr_ptr_o,
    output logic [AddrWidth:0]   rd_ptr_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth:0]   usage_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    typedef logic [AddrWidth:0] ptr_t;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t wr_bin;
    ptr_t rd_bin;
    logic push_acc;
    logic pop_acc;

    // Flags look only at registered pointers, so a push never makes the FIFO
    // look non-empty in the same cycle.
    assign full_o  = is_full(wide_t'(wr_ptr), wide_t'(rd_ptr), AddrWidth);
    assign empty_o = (wr_ptr == rd_ptr);

    assign push_acc = push_i & ~full_o  & ~flush_i;
    assign pop_acc  = pop_i  & ~empty_o & ~flush_i;

    assign wr_en_o = push_acc;
    assign rd_en_o = pop_acc;

    gray_ptr_reg #(
        .AddrWidth(AddrWidth),
        .Speed    (Speed)
    ) u_wr_ptr (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(flush_i),
        .inc_i(push_acc),
        .ptr_o(wr_ptr)
    );

    gray_ptr_reg #(
        .AddrWidth(AddrWidth),
        .Speed    (Speed)
    ) u_rd_ptr (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(flush_i),
        .inc_i(pop_acc),
        .ptr_o(rd_ptr)
    );

    assign wr_bin = ptr_t'(gray2bin(wide_t'(wr_ptr)));
    assign rd_bin = ptr_t'(gray2bin(wide_t'(rd_ptr)));

    assign wr_ptr_o  = wr_ptr;
    assign rd_ptr_o  = rd_ptr;
    assign wr_addr_o = wr_bin[AddrWidth-1:0];
    assign rd_addr_o = rd_bin[AddrWidth-1:0];

    // Modular difference of the extra-bit pointers gives 0..depth directly.
    assign usage_o = wr_bin - rd_bin;

    // Sticky error flags; a flushed request is neither accepted nor an error.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_o) begin
                overflow_o <= 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule
